// File: rtl/peso_liquido.sv
// peso_liquido -- net-weight stage of the scale datapath.
//
// Averages a window of 2^AVG_LOG2 gross samples, subtracts the tare
// (taracabo) and an optional auto-tare offset, clamps the result to
// 0..MAX_NET and flags the clamped cases. It also tracks whether
// consecutive readings have settled. One net_valid pulse is produced
// per window.
//
// Optional feature: define PESO_AUTOTARA_EN to enable the auto-tare
// offset captured on a rising edge of tare_btn. Without the macro,
// tare_btn is ignored and the offset is the constant 0.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   gross_valid  one-cycle strobe qualifying gross
//   gross[11:0]  raw unsigned weight sample
//   taracabo     unsigned tare, sampled in SUB
//   tare_btn     debounced tare button level (auto-tare build only)
//   net[11:0]    net weight, held between updates
//   net_valid    one-cycle pulse when net and the flags update
//   negative     window average was below the total tare (net forced to 0)
//   overload     net exceeded MAX_NET (net forced to MAX_NET)
//   stable       the last STABLE_COUNT comparisons were within STABLE_TOL
//
// state | meaning
// ACC   | accumulating window samples
// SUB   | average, subtract tare, latch results and stability
// OUT   | net_valid pulse; samples arriving here are dropped

module peso_liquido #(
    parameter int AVG_LOG2     = 2,
    parameter int MAX_NET      = 4000,
    parameter int STABLE_TOL   = 2,
    parameter int STABLE_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gross_valid,
    input  logic [11:0] gross,
    input  logic [11:0] taracabo,
    input  logic        tare_btn,
    output logic [11:0] net,
    output logic        net_valid,
    output logic        negative,
    output logic        overload,
    output logic        stable
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
    localparam logic signed [13:0]  MAX_S    = 14'(MAX_NET);
    localparam logic [11:0]         TOL      = 12'(STABLE_TOL);
    localparam logic [2:0]          SC_MAX   = 3'(STABLE_COUNT);

    typedef enum logic [1:0] {ACC, SUB, OUT} state_t;

    state_t               state, state_nxt;
    logic [ACC_W-1:0]     acc;
    logic [AVG_LOG2-1:0]  cnt;
    logic [2:0]           scnt, scnt_nxt;
    logic                 have_prev;
    logic                 last_sample;

    logic [11:0]          avg;
    logic signed [13:0]   diff;
    logic [11:0]          res_net;
    logic                 res_neg, res_ovl;
    logic [11:0]          delta;

    logic [11:0]          offset;
    logic                 capture;

    // ---------------------------------------------------------------
    // Optional auto-tare offset
    // ---------------------------------------------------------------
`ifdef PESO_AUTOTARA_EN
    logic tare_btn_q;
    logic tare_pend;

    assign capture = (state == SUB) && tare_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tare_btn_q <= 1'b0;
            tare_pend  <= 1'b0;
            offset     <= '0;
        end else begin
            tare_btn_q <= tare_btn;
            // An edge seen during SUB survives the clear and applies to
            // the following window.
            tare_pend  <= (tare_pend && (state != SUB)) || (tare_btn && !tare_btn_q);
            if (capture)
                offset <= (avg >= taracabo) ? (avg - taracabo) : '0;
        end
    end
`else
    logic unused_tare_btn;

    assign offset          = '0;
    assign capture         = 1'b0;
    assign unused_tare_btn = tare_btn;
`endif

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    assign last_sample = gross_valid && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ACC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (last_sample) state_nxt = SUB;
            SUB:     state_nxt = OUT;
            OUT:     state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // ---------------------------------------------------------------
    // Arithmetic: the 14-bit signed diff holds the full range
    // -8190..4095 of avg - taracabo - offset.
    // ---------------------------------------------------------------
    assign avg  = acc[ACC_W-1:AVG_LOG2];
    assign diff = $signed({2'b00, avg}) - $signed({2'b00, taracabo})
                - $signed({2'b00, offset});

    always_comb begin
        res_net = '0;
        res_neg = 1'b0;
        res_ovl = 1'b0;
        if (capture) begin
            res_net = '0;
        end else if (diff < 0) begin
            res_neg = 1'b1;
        end else if (diff > MAX_S) begin
            res_net = 12'(MAX_NET);
            res_ovl = 1'b1;
        end else begin
            res_net = diff[11:0];
        end
    end

    // Stability compares the new result against the currently held net.
    assign delta = (res_net >= net) ? (res_net - net) : (net - res_net);

    always_comb begin
        scnt_nxt = scnt;
        if (capture || res_neg || res_ovl)
            scnt_nxt = '0;
        else if (!have_prev)
            scnt_nxt = scnt;
        else if (delta <= TOL)
            scnt_nxt = (scnt == SC_MAX) ? scnt : scnt + 3'd1;
        else
            scnt_nxt = '0;
    end

    // ---------------------------------------------------------------
    // Datapath registers. Results are latched at the end of SUB so that
    // net and the flags change in the same cycle that net_valid is high
    // (the OUT cycle).
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            scnt      <= '0;
            have_prev <= 1'b0;
            net       <= '0;
            net_valid <= 1'b0;
            negative  <= 1'b0;
            overload  <= 1'b0;
        end else begin
            net_valid <= (state == SUB);
            case (state)
                ACC: begin
                    if (gross_valid) begin
                        acc <= acc + {{AVG_LOG2{1'b0}}, gross};
                        cnt <= last_sample ? '0 : cnt + 1'b1;
                    end
                end
                SUB: begin
                    acc       <= '0;
                    net       <= res_net;
                    negative  <= res_neg;
                    overload  <= res_ovl;
                    scnt      <= scnt_nxt;
                    have_prev <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stable = (scnt == SC_MAX);

endmodule

// File: tb/tb_peso_liquido.sv
// Testbench for peso_liquido: directed windows with hand-computed results.
// The driver pushes the expected result of each window into a queue; the
// monitor pops and compares on every net_valid, including the cycle in
// which the pulse is expected.

module tb_peso_liquido;

    logic        clk = 1'b0;
    logic        rst;
    logic        gross_valid;
    logic [11:0] gross;
    logic [11:0] taracabo;
    logic        tare_btn;
    logic [11:0] net;
    logic        net_valid;
    logic        negative;
    logic        overload;
    logic        stable;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int net;
        int neg;
        int ovl;
        int stb;
        int cyc;
    } exp_t;

    exp_t sb[$];

    peso_liquido dut (
        .clk         (clk),
        .rst         (rst),
        .gross_valid (gross_valid),
        .gross       (gross),
        .taracabo    (taracabo),
        .tare_btn    (tare_btn),
        .net         (net),
        .net_valid   (net_valid),
        .negative    (negative),
        .overload    (overload),
        .stable      (stable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst && net_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_net_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("net",       int'(net),      e.net);
                chk("negative",  int'(negative), e.neg);
                chk("overload",  int'(overload), e.ovl);
                chk("stable",    int'(stable),   e.stb);
                chk("out_cycle", cyc,            e.cyc);
            end
        end
    end

    task automatic send_sample(input int v);
        gross       = 12'(v);
        gross_valid = 1'b1;
        @(posedge clk);
        #1;
        gross_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One window of four samples. gap inserts idle cycles between samples;
    // drop keeps gross_valid high for the SUB and OUT cycles with junk data.
    task automatic run_win(input int s0, input int s1, input int s2, input int s3,
                           input int e_net, input int e_neg, input int e_ovl,
                           input int e_stb, input int gap, input bit drop);
        exp_t e;
        send_sample(s0); if (gap > 0) idle(gap);
        send_sample(s1); if (gap > 0) idle(gap);
        send_sample(s2); if (gap > 0) idle(gap);
        send_sample(s3);
        // Last sample was accepted in the cycle ending at the edge just
        // passed (cyc now counts it); the pulse lands two cycles after that.
        e.net = e_net; e.neg = e_neg; e.ovl = e_ovl; e.stb = e_stb;
        e.cyc = cyc + 1;
        sb.push_back(e);
        if (drop) begin
            gross       = 12'd4095;
            gross_valid = 1'b1;
            idle(2);
            gross_valid = 1'b0;
        end
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        gross_valid = 1'b0;
        gross       = '0;
        taracabo    = 12'd40;
        tare_btn    = 1'b0;
        idle(3);
        chk("rst_net",       int'(net),       0);
        chk("rst_net_valid", int'(net_valid), 0);
        chk("rst_negative",  int'(negative),  0);
        chk("rst_overload",  int'(overload),  0);
        chk("rst_stable",    int'(stable),    0);
        rst = 1'b0;
        idle(2);

        //        samples               net neg ovl stb gap drop
        run_win(100, 100, 100, 100,      60, 0, 0, 0, 0, 0);
        run_win(100, 100, 100, 100,      60, 0, 0, 0, 2, 0);
        run_win(100, 100, 100, 100,      60, 0, 0, 0, 0, 0);
        run_win(100, 100, 100, 100,      60, 0, 0, 1, 1, 0);
        run_win(110, 110, 110, 110,      70, 0, 0, 0, 0, 0);
        run_win(110, 110, 110, 110,      70, 0, 0, 0, 0, 0);
        run_win(111, 111, 111, 111,      71, 0, 0, 0, 0, 0);
        run_win(111, 111, 111, 111,      71, 0, 0, 1, 0, 0);
        run_win(112, 112, 112, 112,      72, 0, 0, 1, 0, 0);
        run_win(10, 20, 30, 40,           0, 1, 0, 0, 0, 0);
        run_win(103, 102, 102, 102,      62, 0, 0, 0, 0, 0);
        run_win(4095, 4095, 4095, 4095, 4000, 0, 1, 0, 0, 0);
        run_win(500, 500, 500, 500,     460, 0, 0, 0, 0, 0);
        run_win(500, 500, 500, 500,     460, 0, 0, 0, 0, 1);
        run_win(501, 502, 503, 504,     462, 0, 0, 0, 0, 0);

        // Tare is sampled in SUB, so a change during ACC applies to this window.
        taracabo = 12'd30;
        run_win(100, 100, 100, 100,      70, 0, 0, 0, 0, 0);
        taracabo = 12'd40;

        // Reset mid-window: the partial window is discarded.
        send_sample(999);
        send_sample(999);
        rst = 1'b1;
        idle(2);
        chk("midrst_net",       int'(net),       0);
        chk("midrst_net_valid", int'(net_valid), 0);
        chk("midrst_negative",  int'(negative),  0);
        chk("midrst_overload",  int'(overload),  0);
        chk("midrst_stable",    int'(stable),    0);
        rst = 1'b0;
        idle(2);
        run_win(200, 200, 200, 200,     160, 0, 0, 0, 0, 0);

        // Tare button edge during a window.
        send_sample(140);
        tare_btn = 1'b1;
        send_sample(140);
        tare_btn = 1'b0;
        begin
            exp_t e;
            send_sample(140);
            send_sample(140);
`ifdef PESO_AUTOTARA_EN
            e.net = 0;
`else
            e.net = 100;
`endif
            e.neg = 0; e.ovl = 0; e.stb = 0;
            e.cyc = cyc + 1;
            sb.push_back(e);
            idle(3);
        end
`ifdef PESO_AUTOTARA_EN
        run_win(150, 150, 150, 150,      10, 0, 0, 0, 0, 0);
`else
        run_win(150, 150, 150, 150,     110, 0, 0, 0, 0, 0);
`endif

        idle(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peso_liquido.md
# peso_liquido

Net-weight stage of the scale datapath. Consumes raw gross-weight samples from the ADC front end and the constant tare (`taracabo`, 12-bit, currently 40) produced by the tare block. Averages a window of samples, subtracts the tare, clamps and flags the result, and tracks reading stability. Drives the display/decoder stage with a one-cycle `net_valid` strobe per window.

## Interface
- `AVG_LOG2`, 2: window length is 2^AVG_LOG2 samples (legal 1..4).
- `MAX_NET`, 4000: saturation ceiling for net weight.
- `STABLE_TOL`, 2: maximum |Δnet| between consecutive outputs that still counts as steady.
- `STABLE_COUNT`, 3: number of consecutive steady comparisons required to assert `stable` (legal 1..7).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `gross_valid`  in  1  one-cycle strobe marking a valid `gross` sample.
- `gross`  in  12  unsigned raw weight sample.
- `taracabo`  in  12  unsigned tare from the tare block; sampled in SUB.
- `tare_btn`  in  1  synchronous level from the debounced tare button (used only with the macro).
- `net`  out  12  net weight, unsigned; held between updates.
- `net_valid`  out  1  one-cycle pulse when `net` and the flags update.
- `negative`  out  1  average below total tare; `net` forced to 0.
- `overload`  out  1  net exceeded MAX_NET; `net` = MAX_NET.
- `stable`  out  1  last STABLE_COUNT comparisons within STABLE_TOL.

## Operation
- FSM states: ACC, SUB, OUT.
  - ACC: on each `gross_valid`, acc += gross and cnt++. The sample that brings cnt to 2^AVG_LOG2 moves the FSM to SUB, with cnt cleared.
  - SUB: avg = acc >> AVG_LOG2 (truncating). diff = avg − taracabo − offset, computed at 14 bits signed. acc is cleared. The FSM moves to OUT.
  - OUT: register the results and pulse `net_valid`, then return to ACC.
- Accumulator width is 12+AVG_LOG2 bits and never overflows.
- `gross_valid` arriving in SUB or OUT is dropped and not counted.
- Result rules, applied in OUT:
  - diff < 0: `net`=0, `negative`=1, `overload`=0.
  - diff > MAX_NET: `net`=MAX_NET, `overload`=1, `negative`=0.
  - Otherwise: `net`=diff, both flags 0.
- Stability:
  - A `have_prev` flag is set after the first output.
  - On each OUT with `have_prev`=1, compare the new `net` against the previous `net`.
  - |Δ| ≤ STABLE_TOL increments scnt, saturating at STABLE_COUNT. Otherwise scnt is cleared.
  - `stable` = (scnt == STABLE_COUNT).
  - A negative or overload result also clears scnt.
- offset is 0 unless the macro is defined.

## Timing
- Reset (async assert, sync release) gives:
  - `net`=0 and `net_valid`=0.
  - `negative`=0, `overload`=0, `stable`=0.
  - acc=0, cnt=0, scnt=0, `have_prev`=0, offset=0, state ACC.
- Latency: `net_valid` is high in the 2nd cycle after the cycle in which the last window sample is accepted (ACC→SUB→OUT).
- `net_valid` is high for exactly one cycle. Outputs change only in that cycle.
- Minimum spacing between outputs is 2^AVG_LOG2 accepted samples plus 2 cycles.
- Reset asserted mid-window discards partial acc/cnt. The next output requires a full new window.
- `taracabo` is sampled only in SUB. Changes at other times have no effect until the next window.

## Configuration
- `PESO_AUTOTARA_EN` defined:
  - A rising edge of `tare_btn` (registered compare) sets `tare_pend`.
  - At the next SUB with `tare_pend`=1: offset <= (avg ≥ taracabo) ? avg − taracabo : 0. `tare_pend` is cleared. The output of that window is `net`=0 with both flags cleared.
  - scnt is cleared on capture.
  - offset resets to 0 only on `rst`.
- `PESO_AUTOTARA_EN` undefined: `tare_btn` is ignored, offset is constant 0, and no registers for it are synthesized.

## Test plan
- taracabo=40, AVG_LOG2=2, samples 100,100,100,100 → `net`=60, `negative`=0, `overload`=0. `net_valid` pulses exactly 2 cycles after the 4th sample.
- Samples 10,20,30,40 (avg 25) → `net`=0, `negative`=1. Samples 103,102,102,102 (avg 102, truncated) → `net`=62.
- Samples 4095 ×4 (diff 4055) → `net`=4000, `overload`=1. Next window 500 ×4 → `net`=460, `overload`=0.
- Stability:
  - Four consecutive windows of 100 → `stable`=0,0,0,1 on successive outputs.
  - A fifth window of 110 → `stable`=0.
  - A window of 101 after steady 100 keeps counting.
- `rst` pulsed after 2 of 4 samples, then 4 samples of 200 → a single output with `net`=160. No output is produced from the partial window. All outputs are at reset values during reset.
- With `PESO_AUTOTARA_EN`: window 140 with a `tare_btn` edge → `net`=0 (offset=100). The next window of 150 → `net`=10. Without the macro, the same stimulus → `net`=100, then 110.
